// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding a UART transmitter through an IDLE/LAUNCH/WAIT handshake.
// Optional sticky overflow flag with ovf/ovf_clr ports when UART_TX_FIFO_OVF_EN is defined.
module uart_tx_fifo #(
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [7:0]               wr_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     tx_start,
  output logic [7:0]               tx_data,
  input  logic                     tx_done,
`ifdef UART_TX_FIFO_OVF_EN
  output logic                     ovf,
  input  logic                     ovf_clr,
`endif
  output logic                     busy
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  typedef enum logic [1:0] {StIdle, StLaunch, StWait} state_e;

  state_e          state_q;
  logic [7:0]      mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]   level_q, level_d;
  logic            full_q, empty_q;
  logic            tx_start_q, busy_q;
  logic [7:0]      tx_data_q;
  logic            push, pop;

  // Writes are judged against the registered full flag, so a same-cycle pop cannot rescue them.
  assign push = wr_en && !full_q;
  assign pop  = (state_q == StIdle) && !empty_q;

  always_comb begin
    level_d = level_q;
    unique case ({push, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      level_q <= level_d;
      full_q  <= (level_d == LW'(DEPTH));
      empty_q <= (level_d == '0);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      tx_start_q <= 1'b0;
      tx_data_q  <= 8'h00;
      busy_q     <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (pop) begin
            tx_data_q  <= mem_q[rd_ptr_q];
            tx_start_q <= 1'b1;
            busy_q     <= 1'b1;
            state_q    <= StLaunch;
          end
        end
        StLaunch: begin
          tx_start_q <= 1'b0;
          state_q    <= StWait;
        end
        StWait: begin
          if (tx_done) begin
            busy_q  <= 1'b0;
            state_q <= StIdle;
          end
        end
        default: begin
          tx_start_q <= 1'b0;
          busy_q     <= 1'b0;
          state_q    <= StIdle;
        end
      endcase
    end
  end

`ifdef UART_TX_FIFO_OVF_EN
  logic ovf_q;

  // A dropped write in the same cycle as ovf_clr keeps the flag set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else if (wr_en && full_q) begin
      ovf_q <= 1'b1;
    end else if (ovf_clr) begin
      ovf_q <= 1'b0;
    end
  end

  assign ovf = ovf_q;
`endif

  assign full     = full_q;
  assign empty    = empty_q;
  assign level    = level_q;
  assign tx_start = tx_start_q;
  assign tx_data  = tx_data_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboard bench for uart_tx_fifo: accepted bytes are queued, a monitor checks each launch.
module tb_uart_tx_fifo;

  localparam int unsigned DEPTH = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       full, empty, tx_start, busy;
  logic [4:0] level;
  logic [7:0] tx_data;
  logic       tx_done;
  logic       manual_done, auto_done, auto_en;
`ifdef UART_TX_FIFO_OVF_EN
  logic       ovf;
  logic       ovf_clr = 1'b0;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int n_starts = 0;
  logic [7:0] exp_q [$];

  assign tx_done = manual_done | auto_done;

  always #5 clk = ~clk;

  uart_tx_fifo #(.DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .full     (full),
    .empty    (empty),
    .level    (level),
    .tx_start (tx_start),
    .tx_data  (tx_data),
    .tx_done  (tx_done),
`ifdef UART_TX_FIFO_OVF_EN
    .ovf      (ovf),
    .ovf_clr  (ovf_clr),
`endif
    .busy     (busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic wr1(input logic [7:0] d, input bit accept);
    wr_en   = 1'b1;
    wr_data = d;
    if (accept) exp_q.push_back(d);
    tick();
    wr_en = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    int k = 0;
    while (!(empty && !busy && exp_q.size() == 0) && k < budget) begin
      tick();
      k++;
    end
    chk("drain_done", {31'b0, (k < budget)}, 32'd1);
  endtask

  // Monitor: every launch must match the oldest accepted byte.
  always @(negedge clk) begin
    if (tx_start) begin
      n_starts++;
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_tx_start: got %0h expected none", tx_data);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (tx_data !== e) begin
          n_fail++;
          $display("FAIL tx_data_order: got %0h expected %0h", tx_data, e);
        end
      end
    end
  end

  // Transmitter model: completes about 10 cycles after each launch.
  initial begin
    auto_done = 1'b0;
    forever begin
      @(negedge clk);
      if (auto_en && busy) begin
        repeat (10) @(negedge clk);
        auto_done = 1'b1;
        @(negedge clk);
        auto_done = 1'b0;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int i;
    int s0;
    rst = 1'b1; wr_en = 1'b0; wr_data = 8'h00; manual_done = 1'b0; auto_en = 1'b0;
    repeat (2) tick();
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_tx_start", 32'(tx_start), 32'd0);
    chk("rst_tx_data", 32'(tx_data), 32'h00);
    chk("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    tick();

    // Single byte with latency
    wr1(8'hA5, 1'b1);
    chk("single_level1", 32'(level), 32'd1);
    chk("single_empty0", 32'(empty), 32'd0);
    chk("single_no_start_yet", 32'(tx_start), 32'd0);
    tick();
    chk("single_start", 32'(tx_start), 32'd1);
    chk("single_busy", 32'(busy), 32'd1);
    chk("single_empty1", 32'(empty), 32'd1);
    tick();
    chk("single_start_one_cycle", 32'(tx_start), 32'd0);
    repeat (3) tick();
    chk("single_busy_wait", 32'(busy), 32'd1);
    chk("single_data_hold", 32'(tx_data), 32'hA5);
    manual_done = 1'b1; tick(); manual_done = 1'b0;
    chk("single_busy_done", 32'(busy), 32'd0);
    chk("single_empty_done", 32'(empty), 32'd1);

    // Fill with tx_done withheld
    for (int k = 0; k < 16; k++) wr1(8'(k), 1'b1);
    chk("fill_level15", 32'(level), 32'd15);
    chk("fill_not_full", 32'(full), 32'd0);
    wr1(8'hF0, 1'b1);
    chk("fill_level16", 32'(level), 32'd16);
    chk("fill_full", 32'(full), 32'd1);
    wr1(8'hEE, 1'b0);
    chk("fill_drop_level", 32'(level), 32'd16);
    chk("fill_drop_full", 32'(full), 32'd1);

    // At full, a write in the pop cycle is dropped
    manual_done = 1'b1; tick(); manual_done = 1'b0;
    wr1(8'hDD, 1'b0);
    chk("full_pop_start", 32'(tx_start), 32'd1);
    chk("full_pop_level15", 32'(level), 32'd15);
    chk("full_pop_not_full", 32'(full), 32'd0);
    auto_en = 1'b1;
    wait_drain(1000);

    // Stream 40 bytes through the wrapping buffer
    s0 = n_starts;
    i = 0;
    while (i < 40) begin
      if (!full) begin
        wr_en = 1'b1; wr_data = 8'h10 + 8'(i); exp_q.push_back(wr_data); i++;
      end else begin
        wr_en = 1'b0;
      end
      tick();
    end
    wr_en = 1'b0;
    wait_drain(2000);
    chk("stream_count", 32'(n_starts - s0), 32'd40);
    auto_en = 1'b0;
    repeat (2) tick();

    // Level 5: write during the pop cycle keeps level
    for (int k = 0; k < 6; k++) wr1(8'h40 + 8'(k), 1'b1);
    chk("simul_level5", 32'(level), 32'd5);
    manual_done = 1'b1; tick(); manual_done = 1'b0;
    wr1(8'h46, 1'b1);
    chk("simul_start", 32'(tx_start), 32'd1);
    chk("simul_level_kept", 32'(level), 32'd5);
    tick();
    rst = 1'b1; exp_q.delete(); tick(); rst = 1'b0; tick();

    // Reset mid-WAIT with level 3
    for (int k = 0; k < 4; k++) wr1(8'h50 + 8'(k), 1'b1);
    tick();
    chk("midwait_level3", 32'(level), 32'd3);
    chk("midwait_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    chk("arst_level", 32'(level), 32'd0);
    chk("arst_empty", 32'(empty), 32'd1);
    chk("arst_full", 32'(full), 32'd0);
    chk("arst_tx_start", 32'(tx_start), 32'd0);
    chk("arst_tx_data", 32'(tx_data), 32'h00);
    chk("arst_busy", 32'(busy), 32'd0);
    exp_q.delete();
    tick(); rst = 1'b0; tick();
    s0 = n_starts;
    manual_done = 1'b1; tick(); manual_done = 1'b0;
    repeat (5) tick();
    chk("post_rst_no_start", 32'(n_starts - s0), 32'd0);
    chk("post_rst_level", 32'(level), 32'd0);

    // Spurious tx_done in IDLE
    manual_done = 1'b1; tick(); manual_done = 1'b0;
    chk("spur_tx_start", 32'(tx_start), 32'd0);
    chk("spur_busy", 32'(busy), 32'd0);
    tick();
    chk("spur_empty", 32'(empty), 32'd1);
    chk("spur_no_start", 32'(n_starts - s0), 32'd0);

    // The FSM still works after the spurious pulse
    wr1(8'h77, 1'b1);
    tick();
    chk("after_spur_start", 32'(tx_start), 32'd1);
    tick();
    chk("final_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo.md
UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 SHALL have parameter: DEPTH, 16, FIFO entries; power of two, 2..256.
REQ-002 SHALL have port: clk  in  1  single system clock; all state changes on its rising edge.
REQ-003 SHALL have port: rst  in  1  reset, asynchronous, active-high.
REQ-004 SHALL have port: wr_en  in  1  write strobe; one byte per cycle.
REQ-005 SHALL have port: wr_data  in  8  byte to queue.
REQ-006 SHALL have ports: full  out  1  and empty  out  1, the FIFO status flags.
REQ-007 SHALL have port: level  out  $clog2(DEPTH)+1  current occupancy.
REQ-008 SHALL have port: tx_start  out  1  one-cycle launch pulse to the UART transmitter.
REQ-009 SHALL have port: tx_data  out  8  byte presented to the transmitter.
REQ-010 SHALL have port: tx_done  in  1  one-cycle completion pulse from the transmitter.
REQ-011 SHALL have port: busy  out  1  high while a byte is launched but not completed.

Function
REQ-012 SHALL use a circular buffer; read/write pointers wrap from DEPTH-1 to 0.
REQ-013 SHALL accept a write when wr_en=1 and full=0; level increments at that edge.
REQ-014 SHALL drop a write when full=1, even if a pop occurs the same cycle; contents unchanged.
REQ-015 SHALL, on same-cycle accepted write and pop, perform both with level unchanged.
REQ-016 SHALL drive full=(level==DEPTH), empty=(level==0), all registered, with no combinational input-to-output path.
REQ-017 SHALL implement FSM IDLE, LAUNCH, WAIT.
REQ-018 SHALL, in IDLE with empty=0, pop the head entry into tx_data and go to LAUNCH at that edge.
REQ-019 SHALL assert tx_start=1 only in LAUNCH (exactly one cycle), then go to WAIT.
REQ-020 SHALL, in WAIT, return to IDLE at the edge where tx_done=1.
REQ-021 SHALL ignore tx_done in IDLE and LAUNCH.
REQ-022 SHALL hold tx_data stable from the pop until the next pop.
REQ-023 SHALL drive busy=1 in LAUNCH and WAIT.
REQ-024 Latency: byte written at edge N into an empty FIFO with FSM in IDLE -> popped at edge N+1; tx_start high during cycle N+1..N+2.
REQ-025 SHALL allow back-to-back bytes: tx_done at edge M returns to IDLE; next pop at edge M+1.

Reset
REQ-026 SHALL, on rst=1, immediately clear pointers, level=0, empty=1, full=0, tx_start=0, tx_data=8'h00, busy=0, FSM=IDLE.
REQ-027 SHALL discard queued bytes and any in-flight launch on reset mid-operation; tx_done arriving after reset is ignored.
REQ-028 SHALL NOT reset buffer storage contents.

Configuration
REQ-029 Macro UART_TX_FIFO_OVF_EN: when defined, SHALL add ports ovf  out  1  (sticky overflow) and ovf_clr  in  1.
REQ-030 With UART_TX_FIFO_OVF_EN: ovf sets at the edge after a dropped write; ovf_clr=1 clears it; a same-cycle dropped write wins (ovf stays 1); reset clears it.
REQ-031 Without UART_TX_FIFO_OVF_EN: ovf and ovf_clr ports SHALL NOT exist; dropped writes are silent; other behaviour identical.

Verification
REQ-032 Single byte: write 8'hA5 to empty FIFO -> tx_start one cycle, tx_data=8'hA5, busy=1 until tx_done, then empty=1, busy=0.
REQ-033 Fill: write 16 bytes 8'h00..8'h0F with tx_done withheld -> 1 popped, level=15, then 1 more write -> level=16, full=1; 17th further write dropped (ovf=1 if enabled).
REQ-034 Ordering/wrap: stream 40 bytes 8'h10..8'h37 with tx_done 10 cycles after each tx_start -> transmitted in order, no loss, pointers wrap twice.
REQ-035 Simultaneous: level=5, write during the pop cycle -> level stays 5; at full, write during pop -> write dropped, level 15.
REQ-036 Reset mid-WAIT with level=3 -> outputs at reset values immediately; later tx_done pulse produces no tx_start.
REQ-037 Spurious tx_done in IDLE with empty FIFO -> no state change, tx_start stays 0.
